// File: rtl/acc_shift_pkg.sv
// Shared accumulator definitions for the bit-serial datapath.
package acc_shift_pkg;

  // System accumulator width; used as the WIDTH override where the register is instantiated.
  localparam int unsigned ACC_WIDTH = 8;

  typedef logic [ACC_WIDTH-1:0] acc_word_t;

endpackage

// File: rtl/accumulator_shift_reg_core_if.sv
// Bundle of the load/shift data signals of the accumulator shift register.
// Optional feature macro: ACCUMULATOR_SHIFT_REG_PAROUT_EN adds the parallel readback word q.
interface accumulator_shift_reg_core_if
  import acc_shift_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_WIDTH
) ();

  logic             si;
  logic             l;
  logic [WIDTH-1:0] load;
  logic             sout;
`ifdef ACCUMULATOR_SHIFT_REG_PAROUT_EN
  logic [WIDTH-1:0] q;
`endif

`ifdef ACCUMULATOR_SHIFT_REG_PAROUT_EN
  // Controller side.
  modport master (output si, output l, output load, input sout, input q);
  // Register side.
  modport slave (input si, input l, input load, output sout, output q);
`else
  // Controller side.
  modport master (output si, output l, output load, input sout);
  // Register side.
  modport slave (input si, input l, input load, output sout);
`endif

endinterface

// File: rtl/accumulator_shift_reg_core.sv
// Parallel-load, right-shifting accumulator register: streams the word out LSB-first on Sout
// while the serial result on Si refills it from the MSB end.
// Optional feature macro: ACCUMULATOR_SHIFT_REG_PAROUT_EN exposes the register as output Q.
// Port order is kept as CLK, Si, L, Load, Sout, C so positional instantiations stay valid.
module accumulator_shift_reg_core
  import acc_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Si,
  input  logic             L,
  input  logic [WIDTH-1:0] Load,
  output logic             Sout,
  input  logic             C
`ifdef ACCUMULATOR_SHIFT_REG_PAROUT_EN
  ,
  output logic [WIDTH-1:0] Q
`endif
);

  logic [WIDTH-1:0] q_q;

  // Reset wins over load, load wins over shift; every non-reset edge loads or shifts.
  always_ff @(posedge CLK or posedge C) begin
    if (C) begin
      q_q <= '0;
    end else if (L) begin
      q_q <= Load;
    end else begin
      q_q <= {Si, q_q[WIDTH-1:1]};
    end
  end

  // Serial output comes straight from the flop so it never sees Si or Load directly.
  assign Sout = q_q[0];

`ifdef ACCUMULATOR_SHIFT_REG_PAROUT_EN
  assign Q = q_q;
`endif

endmodule

// File: tb/tb_accumulator_shift_reg_core.sv
// Self-checking bench for accumulator_shift_reg_core: directed scenarios plus random
// load/shift/reset traffic against an arithmetic reference of the register contents.
module tb_accumulator_shift_reg_core;
  import acc_shift_pkg::*;

  localparam int unsigned W = ACC_WIDTH;

  logic clk;
  logic c;
  int   n_checks;
  int   n_errors;
  logic [W-1:0] mdl;

  accumulator_shift_reg_core_if #(.WIDTH(W)) bus ();

  accumulator_shift_reg_core #(.WIDTH(W)) dut (
    .CLK  (clk),
    .Si   (bus.si),
    .L    (bus.l),
    .Load (bus.load),
    .Sout (bus.sout),
    .C    (c)
`ifdef ACCUMULATOR_SHIFT_REG_PAROUT_EN
    ,
    .Q    (bus.q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Parallel word check; only meaningful when the readback port exists.
  task automatic check_q(input string tag, input logic [W-1:0] exp);
`ifdef ACCUMULATOR_SHIFT_REG_PAROUT_EN
    check_val(tag, 32'(bus.q), 32'(exp));
`else
    if (tag.len() < 0) $display("%s %0h", tag, exp);
`endif
  endtask

  // One rising edge; the reference follows the documented reset/load/shift rules.
  task automatic tick();
    @(posedge clk);
    if (c) mdl = '0;
    else if (bus.l) mdl = bus.load;
    else mdl = (mdl >> 1) | (W'(bus.si) << (W - 1));
    #1;
  endtask

  task automatic drive(input logic l, input logic [W-1:0] load, input logic si);
    bus.l    = l;
    bus.load = load;
    bus.si   = si;
  endtask

  initial begin
    logic [W-1:0] pat_out;
    logic [W-1:0] pat_in;
    logic         sout_hold;
    n_checks = 0;
    n_errors = 0;
    mdl      = '0;
    c        = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Power-up reset mid-cycle, no clock edge involved.
    #2;
    c = 1'b1;
    #1;
    check_val("reset_sout", 32'(bus.sout), 32'd0);
    check_q("reset_q", 8'h00);
    tick();
    @(negedge clk);
    c = 1'b0;

    // Load then two shifts.
    drive(1'b1, 8'b1010_0100, 1'b0);
    tick();
    check_val("load_sout", 32'(bus.sout), 32'd0);
    check_q("load_q", 8'b1010_0100);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check_val("shift1_sout", 32'(bus.sout), 32'd0);
    check_q("shift1_q", 8'b1101_0010);
    tick();
    check_val("shift2_sout", 32'(bus.sout), 32'd1);
    check_q("shift2_q", 8'b1110_1001);

    // Reload mid-stream discards the old word.
    drive(1'b1, 8'h00, 1'b1);
    tick();
    check_val("reload_sout", 32'(bus.sout), 32'd0);
    check_q("reload_q", 8'h00);

    // Full serial pass: 5A streams out while C3 streams in.
    pat_out = 8'h5A;
    pat_in  = 8'hC3;
    drive(1'b1, pat_out, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("pass_sout%0d", i), 32'(bus.sout), 32'(pat_out[i]));
      drive(1'b0, 8'h00, pat_in[i]);
      tick();
    end
    check_val("pass_model", 32'(mdl), 32'hC3);
    check_q("pass_q", 8'hC3);

    // Reset held across a loading edge loses the load.
    drive(1'b1, 8'hFF, 1'b0);
    c = 1'b1;
    tick();
    check_val("rstprio_sout", 32'(bus.sout), 32'd0);
    check_q("rstprio_q", 8'h00);
    @(negedge clk);
    c = 1'b0;
    tick();
    check_val("postrst_sout", 32'(bus.sout), 32'd1);
    check_q("postrst_q", 8'hFF);

    // Input activity between edges must not disturb the register.
    sout_hold = bus.sout;
    for (int i = 0; i < 6; i++) begin
      drive(i[0], W'($urandom), ~bus.si);
      #0.5;
    end
    check_val("glitch_sout", 32'(bus.sout), 32'(sout_hold));
    check_q("glitch_q", 8'hFF);
    mdl = 8'hFF;

    // Random traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 3), W'($urandom), 1'($urandom));
      tick();
      check_val("rand_sout", 32'(bus.sout), 32'(mdl[0]));
      check_q("rand_q", mdl);
      if ($urandom_range(0, 29) == 0) begin
        c = 1'b1;
        #1;
        mdl = '0;
        check_val("rand_rst_sout", 32'(bus.sout), 32'd0);
        check_q("rand_rst_q", mdl);
        #1;
        c = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
